seq_div_32by16: RTL
===================

// Module: seq_div_32by16
// PURPOSE
//   Sequential restoring divider: the inverse of the 16x16 array multiplier.
//   Divides a 2*W-bit dividend by a W-bit divisor and returns a W-bit quotient and remainder.
//   Uses one trial-subtract per clock, so area stays small versus an unrolled array.
//   Sits beside the multiplier in the arithmetic datapath, behind a start/busy/done handshake.
// PARAMETERS
//   W  16  operand width; dividend is 2*W bits; quotient and remainder are W bits each
// PORTS
//   clk          in   1     single clock, rising edge
//   rst_n        in   1     synchronous, active-low reset
//   start        in   1     request; accepted only when busy==0
//   dividend     in   2*W   sampled on the accept edge only
//   divisor      in   W     sampled on the accept edge only
//   busy         out  1     high while iterating (state RUN)
//   done         out  1     one-cycle pulse; results valid from this cycle on
//   quotient     out  W     held until the next accepted start
//   remainder    out  W     held until the next accepted start
//   div_by_zero  out  1     held with results
//   overflow     out  1     held with results
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, quotient, remainder, div_by_zero and overflow all 0.
//     rst_n low mid-operation aborts immediately, with no done pulse.
//   States: IDLE, RUN, DONE.
//     IDLE/DONE -> RUN   on start when divisor!=0 and dividend[2W-1:W] < divisor.
//     IDLE/DONE -> DONE  on start when divisor==0 or dividend[2W-1:W] >= divisor (early exit).
//     RUN -> DONE        on the edge that performs the W-th iteration.
//     DONE -> IDLE       unconditionally if start==0.
//   Accept edge E0:
//     - load partial remainder PR (W+1 bits) = {1'b0, dividend[2W-1:W]};
//     - load shift register Q = dividend[W-1:0];
//     - load iteration counter = W; clear both flags.
//   RUN edges E1..EW, one iteration each (MSB of Q first):
//     - T = {PR[W-1:0], Q[W-1]} - {1'b0, divisor};
//     - if T is non-negative: PR=T, Q={Q[W-2:0],1}; else PR={PR[W-1:0],Q[W-1]}, Q={Q[W-2:0],0};
//     - decrement the counter.
//   Normal latency: done is high in the cycle after EW (W edges after accept).
//     Then quotient=Q and remainder=PR[W-1:0].
//   Early exits: done is high in the cycle after E0.
//     - divisor==0: div_by_zero=1, overflow=0, quotient='1, remainder=dividend[W-1:0].
//     - divisor!=0 and high half >= divisor: overflow=1, quotient='1, remainder=0.
//     - divisor==0 takes priority over overflow.
//   Handshake rules:
//     - start while busy==1 is ignored; the operands are not resampled.
//     - start in the DONE cycle is accepted (back-to-back). done still pulses that cycle;
//       quotient, remainder and flags update at E0 of the new operation.
//   Arithmetic: unsigned only. The trial subtract is W+1 bits wide, so PR never overflows.
//     The counter is $clog2(W+1) bits.
// STRUCTURE
//   Package div_pkg:
//     - state enum {IDLE, RUN, DONE};
//     - default W;
//     - localparam for the counter width.
//   Sub-module div_step (combinational, one restoring iteration):
//     - inputs: pr[W:0], next bit, divisor;
//     - outputs: new pr, quotient bit.
//   Top holds the FSM, counter and registers, and instantiates one div_step.
// TESTING
//   1 Basic: 1000/7 -> busy for 16 cycles, done pulse, quotient=142, remainder=6, both flags 0.
//   2 Max non-overflow: 0xFFFE0001/0xFFFF -> quotient=0xFFFF, remainder=0, overflow=0.
//   3 Div by zero: 0x12345678/0 -> done 1 cycle after accept, div_by_zero=1,
//     quotient=0xFFFF, remainder=0x5678.
//   4 Overflow: 0x00010000/1 -> done 1 cycle after accept, overflow=1,
//     quotient=0xFFFF, remainder=0.
//   5 Start while busy: 100/3 started, then start 50/5 at cycle 5 -> ignored;
//     result quotient=33, remainder=1.
//   6 Reset and back-to-back:
//     - rst_n low at cycle 8 of 1000/7 -> all outputs 0 next cycle, no done;
//     - restart 1000/7 -> done, with start asserted in the done cycle for 9/2 -> quotient=4, remainder=1.
//   Scoreboard: every done checks quotient*divisor+remainder==dividend and remainder<divisor
//     (flags 0), across 10k random non-overflow operands.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    // Default operand width: dividend is 2*DIV_W bits, quotient/remainder DIV_W bits.
    localparam int DIV_W = 16;

    // Iteration counter must hold the value DIV_W itself.
    localparam int DIV_CNT_W = $clog2(DIV_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Counter width for an arbitrary operand width.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
module div_step #(
    parameter int W = 16
) (
    input  logic [W:0]   pr_in,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W:0]   pr_out,
    output logic         q_bit
);

    logic [W+1:0] shifted;
    logic [W:0]   trial;

    // Trial subtract; the compare decides whether the subtraction is kept.
    always_comb begin
        shifted = {pr_in, bit_in};
        trial   = shifted[W:0] - {1'b0, divisor};
        q_bit   = (shifted >= {2'b00, divisor});
        pr_out  = q_bit ? trial : shifted[W:0];
    end

endmodule

// File: rtl/seq_div_32by16.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one
// quotient bit per clock, behind a start/busy/done handshake.
module seq_div_32by16
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CNT_W = cnt_width(W);

    div_state_e     state_q, state_d;
    logic [W:0]     pr_q, pr_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           dbz_q, dbz_d;
    logic           ovf_q, ovf_d;

    logic [W:0]     step_pr;
    logic           step_bit;

    // Single iteration datapath; fed the current partial remainder and
    // the MSB of the quotient shift register.
    div_step #(.W(W)) u_step (
        .pr_in   (pr_q),
        .bit_in  (q_q[W-1]),
        .divisor (dvs_q),
        .pr_out  (step_pr),
        .q_bit   (step_bit)
    );

    // Next-state logic: accept in IDLE/DONE, iterate in RUN, early-exit
    // straight to DONE when the result cannot fit or the divisor is zero.
    always_comb begin
        state_d = state_q;
        pr_d    = pr_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            RUN: begin
                pr_d  = step_pr;
                q_d   = {q_q[W-2:0], step_bit};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: begin
                if (start) begin
                    dvs_d = divisor;
                    cnt_d = CNT_W'(W);
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
                    if (divisor == '0) begin
                        // Zero divisor wins over overflow; low half passes through.
                        dbz_d   = 1'b1;
                        q_d     = '1;
                        pr_d    = {1'b0, dividend[W-1:0]};
                        state_d = DONE;
                    end else if (dividend[2*W-1:W] >= divisor) begin
                        // Quotient would need more than W bits.
                        ovf_d   = 1'b1;
                        q_d     = '1;
                        pr_d    = '0;
                        state_d = DONE;
                    end else begin
                        pr_d    = {1'b0, dividend[2*W-1:W]};
                        q_d     = dividend[W-1:0];
                        state_d = RUN;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and datapath registers; active-low reset aborts any operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pr_q    <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pr_q    <= pr_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs decode directly from registers, so they are glitch-free.
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = q_q;
    assign remainder   = pr_q[W-1:0];
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
